// File: rtl/vgakb_pkg.sv
// Shared types and constants for the VGA tile-map / keyboard player subsystem.
package vgakb_pkg;

    localparam int unsigned UNIT     = 64;
    localparam int unsigned HMAXTILE = 9;
    localparam int unsigned VMAXTILE = 5;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        PATH  = 2'd0,
        BLOCK = 2'd1,
        WATER = 2'd2
    } tile_t;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StPending  = 2'd1,
        StCheck    = 2'd2,
        StCooldown = 2'd3
    } pmc_state_t;

endpackage

// File: rtl/tile_rules.sv
// Combinational tile classifier; shared with the pixel generator so the rendered map
// and the movement legality always agree.
module tile_rules
    import vgakb_pkg::*;
(
    input  logic [3:0] h_i,
    input  logic [3:0] v_i,
    output tile_t      tile_o
);

    always_comb begin
        if (h_i % 4'd3 == 4'd0) begin
            tile_o = WATER;
        end else if (v_i % 4'd4 == 4'd0) begin
            tile_o = BLOCK;
        end else begin
            tile_o = PATH;
        end
    end

endmodule

// File: rtl/player_move_ctrl.sv
// Player marker controller: queues one direction command, resolves it at frame start
// against the tile map, then cools down for a number of frames.
module player_move_ctrl
    import vgakb_pkg::*;
#(
    parameter int unsigned START_H     = 1,
    parameter int unsigned START_V     = 1,
    parameter int unsigned HOLD_FRAMES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [1:0] key_dir,
    input  logic       frame_start,
    output logic [3:0] curAh,
    output logic [3:0] curAv,
    output logic       move_ok,
    output logic       move_blocked,
    output logic       busy
);

    localparam int unsigned CntW = (HOLD_FRAMES == 0) ? 1 : $clog2(HOLD_FRAMES + 1);
    localparam logic signed [4:0] HMax = 5'(HMAXTILE);
    localparam logic signed [4:0] VMax = 5'(VMAXTILE);

    pmc_state_t       state_q;
    dir_t             dir_q;
    logic [CntW-1:0]  cnt_q;
    logic [3:0]       cur_h_q, cur_v_q;
    logic             ok_q, blk_q;

    logic signed [4:0] tgt_h, tgt_v;
    logic              in_grid, legal;
    tile_t             tgt_tile;

    // Signed 5-bit target so that -1 and 10 fall outside the grid rather than wrapping.
    always_comb begin
        tgt_h = $signed({1'b0, cur_h_q});
        tgt_v = $signed({1'b0, cur_v_q});
        case (dir_q)
            UP:      tgt_v = tgt_v - 5'sd1;
            DOWN:    tgt_v = tgt_v + 5'sd1;
            LEFT:    tgt_h = tgt_h - 5'sd1;
            RIGHT:   tgt_h = tgt_h + 5'sd1;
            default: tgt_h = tgt_h;
        endcase
        in_grid = (tgt_h >= 5'sd0) && (tgt_h <= HMax) && (tgt_v >= 5'sd0) && (tgt_v <= VMax);
    end

    tile_rules u_tile_rules (
        .h_i    (tgt_h[3:0]),
        .v_i    (tgt_v[3:0]),
        .tile_o (tgt_tile)
    );

    assign legal = in_grid && (tgt_tile == PATH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            dir_q   <= UP;
            cnt_q   <= '0;
            cur_h_q <= 4'(START_H);
            cur_v_q <= 4'(START_V);
            ok_q    <= 1'b0;
            blk_q   <= 1'b0;
        end else begin
            ok_q  <= 1'b0;
            blk_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (key_valid) begin
                        dir_q   <= dir_t'(key_dir);
                        state_q <= StPending;
                    end
                end
                StPending: begin
                    if (frame_start) begin
                        state_q <= StCheck;
                    end else if (key_valid) begin
                        dir_q <= dir_t'(key_dir);
                    end
                end
                StCheck: begin
                    if (legal) begin
                        cur_h_q <= tgt_h[3:0];
                        cur_v_q <= tgt_v[3:0];
                        ok_q    <= 1'b1;
                    end else begin
                        blk_q <= 1'b1;
                    end
                    if (HOLD_FRAMES > 0) begin
                        cnt_q   <= CntW'(HOLD_FRAMES);
                        state_q <= StCooldown;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StCooldown: begin
                    if (frame_start) begin
                        cnt_q <= cnt_q - CntW'(1);
                        if (cnt_q == CntW'(1)) begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign curAh        = cur_h_q;
    assign curAv        = cur_v_q;
    assign move_ok      = ok_q;
    assign move_blocked = blk_q;
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_player_move_ctrl.sv
// Bench for player_move_ctrl: two instances (default start/hold, and start (1,5) with no
// cooldown) checked every cycle against a behavioural model, plus literal checkpoints.
module tb_player_move_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_valid = 1'b0;
    logic [1:0] key_dir = 2'd0;
    logic       frame_start = 1'b0;

    logic [3:0] a_h, a_v, b_h, b_v;
    logic       a_ok, a_blk, a_busy, b_ok, b_blk, b_busy;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    player_move_ctrl u_dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_valid    (key_valid),
        .key_dir      (key_dir),
        .frame_start  (frame_start),
        .curAh        (a_h),
        .curAv        (a_v),
        .move_ok      (a_ok),
        .move_blocked (a_blk),
        .busy         (a_busy)
    );

    player_move_ctrl #(
        .START_H     (1),
        .START_V     (5),
        .HOLD_FRAMES (0)
    ) u_dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_valid    (key_valid),
        .key_dir      (key_dir),
        .frame_start  (frame_start),
        .curAh        (b_h),
        .curAv        (b_v),
        .move_ok      (b_ok),
        .move_blocked (b_blk),
        .busy         (b_busy)
    );

    // ---------------- behavioural model ----------------
    // phase: 0 waiting for a key, 1 key queued, 2 resolving, 3 frames left to wait
    typedef struct {
        int phase;
        int dir;
        int h;
        int v;
        int frames_left;
        bit ok;
        bit blk;
    } mdl_t;

    function automatic bit legal(int h, int v);
        if (h < 0 || h > 9 || v < 0 || v > 5) return 1'b0;
        if (h % 3 == 0) return 1'b0;
        if (v % 4 == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic mdl_t mdl_reset(int sh, int sv);
        mdl_t m;
        m.phase = 0; m.dir = 0; m.h = sh; m.v = sv; m.frames_left = 0;
        m.ok = 1'b0; m.blk = 1'b0;
        return m;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, bit kv, int kd, bit fs, int hold);
        mdl_t n = m;
        int th, tv;
        n.ok  = 1'b0;
        n.blk = 1'b0;
        if (m.phase == 0) begin
            if (kv) begin n.phase = 1; n.dir = kd; end
        end else if (m.phase == 1) begin
            if (fs) n.phase = 2;
            else if (kv) n.dir = kd;
        end else if (m.phase == 2) begin
            th = m.h + ((m.dir == 3) ? 1 : (m.dir == 2) ? -1 : 0);
            tv = m.v + ((m.dir == 1) ? 1 : (m.dir == 0) ? -1 : 0);
            if (legal(th, tv)) begin n.h = th; n.v = tv; n.ok = 1'b1; end
            else n.blk = 1'b1;
            n.frames_left = hold;
            n.phase = (hold > 0) ? 3 : 0;
        end else begin
            if (fs) begin
                n.frames_left = m.frames_left - 1;
                if (n.frames_left == 0) n.phase = 0;
            end
        end
        return n;
    endfunction

    mdl_t ma = mdl_reset(1, 1);
    mdl_t mb = mdl_reset(1, 5);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= mdl_reset(1, 1);
            mb <= mdl_reset(1, 5);
        end else begin
            ma <= mdl_step(ma, key_valid, int'(key_dir), frame_start, 8);
            mb <= mdl_step(mb, key_valid, int'(key_dir), frame_start, 0);
        end
    end

    // ---------------- checking ----------------
    task automatic cmp(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("a_curAh", int'(a_h), ma.h);
            cmp("a_curAv", int'(a_v), ma.v);
            cmp("a_move_ok", int'(a_ok), int'(ma.ok));
            cmp("a_move_blocked", int'(a_blk), int'(ma.blk));
            cmp("a_busy", int'(a_busy), int'(ma.phase != 0));
            cmp("b_curAh", int'(b_h), mb.h);
            cmp("b_curAv", int'(b_v), mb.v);
            cmp("b_move_ok", int'(b_ok), int'(mb.ok));
            cmp("b_move_blocked", int'(b_blk), int'(mb.blk));
            cmp("b_busy", int'(b_busy), int'(mb.phase != 0));
        end
    end

    task automatic drive(input bit kv, input int kd, input bit fs);
        @(posedge clk);
        #1;
        key_valid   = kv;
        key_dir     = 2'(kd);
        frame_start = fs;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0);
    endtask

    task automatic frame_then_idle(input int n);
        drive(1'b0, 0, 1'b1);
        idle(n);
    endtask

    initial begin
        int fs_wait;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        #20;
        @(negedge clk);
        cmp("lit_reset_a_h", int'(a_h), 1);
        cmp("lit_reset_a_v", int'(a_v), 1);
        cmp("lit_reset_a_busy", int'(a_busy), 0);
        cmp("lit_reset_a_pulse", int'(a_ok | a_blk), 0);
        cmp("lit_reset_b_v", int'(b_v), 5);
        #2 rst_n = 1'b1;

        // Reset while a key is queued: back to idle at once, no pulse.
        drive(1'b1, 3, 1'b0);
        idle(1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        cmp("lit_midreset_busy", int'(a_busy), 0);
        cmp("lit_midreset_h", int'(a_h), 1);
        cmp("lit_midreset_ok", int'(a_ok), 0);
        #2 rst_n = 1'b1;

        // Left then right in one frame: only right applies.
        drive(1'b1, 2, 1'b0);
        drive(1'b1, 3, 1'b0);
        idle(2);
        frame_then_idle(3);
        @(negedge clk);
        cmp("lit_lastkey_a_h", int'(a_h), 2);
        cmp("lit_lastkey_a_v", int'(a_v), 1);
        cmp("lit_lastkey_b_h", int'(b_h), 2);

        // Keys during cooldown ignored; key right after the 8th frame accepted.
        drive(1'b1, 3, 1'b0);
        for (int i = 0; i < 7; i++) frame_then_idle(3);
        @(negedge clk);
        cmp("lit_cooldown_busy", int'(a_busy), 1);
        drive(1'b0, 0, 1'b1);
        drive(1'b1, 3, 1'b0);
        idle(1);
        @(negedge clk);
        cmp("lit_exit_key_busy", int'(a_busy), 1);
        frame_then_idle(3);
        @(negedge clk);
        cmp("lit_water_blocked_h", int'(a_h), 2);

        for (int i = 0; i < 8; i++) frame_then_idle(2);
        drive(1'b1, 1, 1'b0);
        frame_then_idle(3);
        @(negedge clk);
        cmp("lit_down_a_v", int'(a_v), 2);
        cmp("lit_offgrid_b_v", int'(b_v), 5);
        cmp("lit_offgrid_b_h", int'(b_h), 2);

        // Randomized traffic with occasional asynchronous reset.
        fs_wait = 10;
        for (int i = 0; i < 5000; i++) begin
            bit fs;
            fs = (fs_wait == 0);
            fs_wait = fs ? $urandom_range(4, 30) : fs_wait - 1;
            drive(($urandom_range(0, 4) == 0), $urandom_range(0, 3), fs);
            if ($urandom_range(0, 599) == 0) begin
                #2 rst_n = 1'b0;
                #3 rst_n = 1'b1;
            end
        end
        idle(2);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/player_move_ctrl.md
# player_move_ctrl

Sequences the player marker position (`curAh`, `curAv`) consumed by the tile-map pixel generator. Accepts direction commands from the keyboard decoder, queues one pending move, and checks it against the fixed 10×6 tile map. It commits legal moves only at frame start, so the marker never tears mid-frame. After each resolved move it enforces a frame-count cooldown so a held key steps at a controlled rate.

## Interface
- `START_H`, default 1: tile column after reset; must be a PATH tile.
- `START_V`, default 1: tile row after reset; must be a PATH tile.
- `HOLD_FRAMES`, default 8: number of frame_start pulses to wait after a resolved move; 0 disables the cooldown.
- `clk` in 1: system clock, the single clock domain.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `key_valid` in 1: single-cycle pulse; a direction command is present.
- `key_dir` in 2: direction code. 0 = up, 1 = down, 2 = left, 3 = right. Sampled only when `key_valid` is high.
- `frame_start` in 1: single-cycle pulse at the start of vertical blanking, from the VGA timing block.
- `curAh` out 4: current tile column, 0..9.
- `curAv` out 4: current tile row, 0..5.
- `move_ok` out 1: single-cycle pulse; a move was committed.
- `move_blocked` out 1: single-cycle pulse; a move was rejected.
- `busy` out 1: high in any state other than IDLE.

## Operation
- **Tile rules.** These match the pixel generator.
  - Column h with h%3==0 is WATER.
  - Otherwise, row v with v%4==0 is BLOCK.
  - Otherwise the tile is PATH.
  - A target is legal only if it lies in h 0..9, v 0..5 and is PATH.
  - There is no wrap-around. Off-grid targets (up at v=0, down at v=5, left at h=0, right at h=9) are blocked.
- **States:** IDLE, PENDING, CHECK, COOLDOWN.
- **IDLE.**
  - On `key_valid`: latch `key_dir`, go to PENDING.
  - A `frame_start` in the same cycle is not consumed; the move waits for the next frame.
- **PENDING.**
  - `key_valid` overwrites the latched direction; the last key before the frame wins.
  - On `frame_start`: go to CHECK. A `key_valid` in that same cycle is dropped.
- **CHECK.** Lasts one cycle.
  - Compute the target from the registered position and direction.
  - Legal target: load `curAh`/`curAv` and pulse `move_ok`.
  - Illegal target: position unchanged, pulse `move_blocked`.
  - Next state is COOLDOWN if `HOLD_FRAMES`>0, otherwise IDLE.
- **COOLDOWN.**
  - Load the frame counter with `HOLD_FRAMES` on entry.
  - Decrement it on each `frame_start`.
  - On the `frame_start` that reaches 0, go to IDLE.
  - `key_valid` is dropped in CHECK and COOLDOWN. Blocked moves also cool down.
- **Arithmetic.**
  - Target computation uses 5-bit signed intermediates, so that -1 and 10 are detected as off-grid.
  - The frame counter is $clog2(HOLD_FRAMES+1) bits wide, minimum 1.

## Timing
- **Reset values:**
  - `curAh`=`START_H`, `curAv`=`START_V`
  - `move_ok`=0, `move_blocked`=0, `busy`=0
  - state IDLE, latched direction 0, counter 0.
- **Reset mid-operation:** any pending or cooling move is discarded immediately, asynchronously. No pulse is emitted.
- **Latency.**
  - `key_valid` at cycle t → PENDING and `busy`=1 at t+1.
  - `frame_start` at cycle f in PENDING → CHECK at f+1.
  - At f+2: new position and the `move_ok`/`move_blocked` pulse, both registered and lasting one cycle.
- **Pulses.** `move_ok` and `move_blocked` are mutually exclusive and never high in consecutive cycles.
- **Cooldown exit.** With cooldown, the controller returns to IDLE one cycle after the `HOLD_FRAMES`-th `frame_start` following CHECK. A `key_valid` in that IDLE cycle is accepted.
- **Output stability.** Position outputs change only in the cycle after CHECK, which is at most 2 cycles into vertical blanking.

## Structure
- **Shared package `vgakb_pkg`** holds:
  - `UNIT`, `HMAXTILE`=9, `VMAXTILE`=5
  - direction enum `dir_t` (UP, DOWN, LEFT, RIGHT)
  - tile enum `tile_t` (PATH, BLOCK, WATER)
  - state enum for this block.
- **Sub-module `tile_rules`:** combinational (h, v) → `tile_t`. It is reused by the pixel generator so map legality and rendering cannot diverge.

## Test plan
- Reset → `curAh`=1, `curAv`=1, `busy`=0, no pulses. Assert `rst_n` low while in PENDING → IDLE at once, position unchanged, no pulse.
- From (1,1): right, then `frame_start` at f → `move_ok` at f+2 and (2,1). Right again after cooldown → target (3,1) is WATER → `move_blocked`, position stays (2,1).
- From (1,1): up → (1,0) is BLOCK → blocked. Down, down → (1,2), (1,3). Down → (1,4) is BLOCK → blocked.
- `START_V`=5, `START_H`=1: down → off-grid → blocked, no wrap to v=0.
- Left then right within one frame in PENDING → only right applied: (2,1), one `move_ok`.
- `HOLD_FRAMES`=8: keys during cooldown are ignored. A key after the 8th `frame_start` is accepted. `HOLD_FRAMES`=0: back-to-back moves on consecutive frames.
